// File: rtl/reg_select_bank.sv
// Operand-select bank: index 0 is the live ALU result, indices 1..NREGS-1 are registers.
// 1-cycle registered read with same-cycle write forwarding; no backpressure, accepts every cycle.
module reg_select_bank #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          alu_out,
  input  logic                      wr_en,
  input  logic [$clog2(NREGS)-1:0]  wr_sel,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [$clog2(NREGS)-1:0]  rd_sel,
  output logic [WIDTH-1:0]          a_out,
  output logic                      a_valid,
  output logic                      wr_err
);

  localparam int SEL_W = $clog2(NREGS);

  logic [WIDTH-1:0] regs [1:NREGS-1];
  logic [WIDTH-1:0] rd_src;

  // One storage register per non-zero index; index 0 has none.
  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[i] <= '0;
      end else if (wr_en && wr_sel == IDX) begin
        regs[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_src = alu_out;
    if (rd_sel != '0) begin
      for (int i = 1; i < NREGS; i++) begin
        if (rd_sel == SEL_W'(i)) begin
          rd_src = regs[i];
        end
      end
      // A write landing on the same index this cycle wins over the stored value.
      if (wr_en && wr_sel == rd_sel) begin
        rd_src = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out   <= '0;
      a_valid <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      if (rd_en) begin
        a_out <= rd_src;
      end
      a_valid <= rd_en;
      wr_err  <= wr_en && (wr_sel == '0);
    end
  end

endmodule

// File: tb/tb_reg_select_bank.sv
// Bench for reg_select_bank: two instances (8b/4 and 16b/8) driven by directed and random
// stimulus, checked every cycle against an array-based reference model.
module tb_reg_select_bank;

  logic clk;
  logic rst_n;

  logic [7:0]  a_alu, a_wr_data, a_out;
  logic [1:0]  a_wr_sel, a_rd_sel;
  logic        a_wr_en, a_rd_en, a_valid, a_err;

  logic [15:0] b_alu, b_wr_data, b_out;
  logic [2:0]  b_wr_sel, b_rd_sel;
  logic        b_wr_en, b_rd_en, b_valid, b_err;

  int n_vec;
  int n_err;

  // Reference state: register contents and expected registered outputs.
  int ma [0:3];
  int mb [0:7];
  int ea_out, ea_v, ea_err;
  int eb_out, eb_v, eb_err;

  reg_select_bank #(.WIDTH(8), .NREGS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .alu_out(a_alu),
    .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_sel(a_rd_sel),
    .a_out(a_out), .a_valid(a_valid), .wr_err(a_err)
  );

  reg_select_bank #(.WIDTH(16), .NREGS(8)) u_b (
    .clk(clk), .rst_n(rst_n), .alu_out(b_alu),
    .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_sel(b_rd_sel),
    .a_out(b_out), .a_valid(b_valid), .wr_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string phase);
    chk({phase, " a.a_out"},   32'(a_out),   32'(ea_out));
    chk({phase, " a.a_valid"}, 32'(a_valid), 32'(ea_v));
    chk({phase, " a.wr_err"},  32'(a_err),   32'(ea_err));
    chk({phase, " b.a_out"},   32'(b_out),   32'(eb_out));
    chk({phase, " b.a_valid"}, 32'(b_valid), 32'(eb_v));
    chk({phase, " b.wr_err"},  32'(b_err),   32'(eb_err));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ma[i] = 0;
    for (int i = 0; i < 8; i++) mb[i] = 0;
    ea_out = 0; ea_v = 0; ea_err = 0;
    eb_out = 0; eb_v = 0; eb_err = 0;
  endtask

  task automatic idle();
    a_wr_en = 0; a_rd_en = 0; b_wr_en = 0; b_rd_en = 0;
  endtask

  // Advance one clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic tick(input string phase);
    if (rst_n) begin
      if (a_rd_en) begin
        if (a_rd_sel == 0)                            ea_out = int'(a_alu);
        else if (a_wr_en && a_wr_sel == a_rd_sel)     ea_out = int'(a_wr_data);
        else                                          ea_out = ma[a_rd_sel];
      end
      ea_v   = int'(a_rd_en);
      ea_err = int'(a_wr_en && a_wr_sel == 0);
      if (a_wr_en && a_wr_sel != 0) ma[a_wr_sel] = int'(a_wr_data);

      if (b_rd_en) begin
        if (b_rd_sel == 0)                            eb_out = int'(b_alu);
        else if (b_wr_en && b_wr_sel == b_rd_sel)     eb_out = int'(b_wr_data);
        else                                          eb_out = mb[b_rd_sel];
      end
      eb_v   = int'(b_rd_en);
      eb_err = int'(b_wr_en && b_wr_sel == 0);
      if (b_wr_en && b_wr_sel != 0) mb[b_wr_sel] = int'(b_wr_data);
    end
    @(posedge clk);
    #1;
    check_all(phase);
  endtask

  task automatic a_write(input int sel, input int data);
    a_wr_en = 1; a_wr_sel = 2'(sel); a_wr_data = 8'(data);
  endtask

  task automatic a_read(input int sel);
    a_rd_en = 1; a_rd_sel = 2'(sel);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_alu = '0; a_wr_data = '0; a_wr_sel = '0; a_rd_sel = '0;
    b_alu = '0; b_wr_data = '0; b_wr_sel = '0; b_rd_sel = '0;
    idle();
    model_reset();
    #2;
    check_all("por");
    #6 rst_n = 1'b1;

    // Put 0x55 on a_out, then assert reset between edges.
    a_alu = 8'h55; a_read(0);
    b_alu = 16'h1234; b_rd_en = 1; b_rd_sel = 0;
    tick("pre_rst");
    chk("pre_rst a_out=55", 32'(a_out), 32'h55);
    idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    #2 rst_n = 1'b1;
    for (int i = 1; i < 4; i++) begin
      idle(); a_read(i);
      tick("rst_rd");
    end

    // Basic select.
    idle(); a_alu = 8'h01;
    for (int i = 1; i < 4; i++) begin
      idle(); a_write(i, i + 1);
      tick("wr_basic");
    end
    for (int i = 0; i < 4; i++) begin
      idle(); a_read(i);
      tick("rd_basic");
      chk("basic value", 32'(a_out), 32'(i + 1));
      chk("basic valid", 32'(a_valid), 32'd1);
    end

    // Forwarding on reg 2 (holds 3).
    idle(); a_write(2, 8'hA5); a_read(2);
    tick("fwd");
    chk("fwd a5", 32'(a_out), 32'hA5);
    idle(); a_read(2);
    tick("fwd_after");
    chk("fwd_after a5", 32'(a_out), 32'hA5);
    idle(); a_write(2, 3);
    tick("restore");

    // Illegal write to index 0.
    idle(); a_alu = 8'h10; a_write(0, 8'hFF);
    tick("illegal");
    chk("illegal err", 32'(a_err), 32'd1);
    idle(); a_read(0);
    tick("illegal_clr");
    chk("illegal err clr", 32'(a_err), 32'd0);
    chk("illegal rd0", 32'(a_out), 32'h10);
    for (int i = 1; i < 4; i++) begin
      idle(); a_read(i);
      tick("illegal_regs");
    end

    // Hold while writing reg 3.
    idle(); a_read(3);
    tick("hold_rd");
    for (int k = 0; k < 3; k++) begin
      idle(); a_write(3, 8'h77);
      tick("hold");
      chk("hold a_out", 32'(a_out), 32'h4);
      chk("hold valid", 32'(a_valid), 32'd0);
    end
    idle(); a_read(3);
    tick("hold_after");
    chk("hold_after 77", 32'(a_out), 32'h77);

    // Wide/deep instance sweep.
    for (int i = 1; i < 8; i++) begin
      idle(); b_wr_en = 1; b_wr_sel = 3'(i); b_wr_data = 16'(i * 16'h1111);
      tick("sweep_wr");
    end
    b_alu = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      idle(); b_rd_en = 1; b_rd_sel = 3'(i);
      tick("sweep_rd");
      chk("sweep value", 32'(b_out), (i == 0) ? 32'hBEEF : 32'(i * 16'h1111));
    end

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      a_alu = 8'($urandom);      b_alu = 16'($urandom);
      a_wr_en = 1'($urandom);    b_wr_en = 1'($urandom);
      a_rd_en = ($urandom_range(0, 3) != 0);
      b_rd_en = ($urandom_range(0, 3) != 0);
      a_wr_sel = 2'($urandom);   a_rd_sel = 2'($urandom);
      b_wr_sel = 3'($urandom);
      b_rd_sel = ($urandom_range(0, 2) == 0) ? b_wr_sel : 3'($urandom);
      a_wr_data = 8'($urandom);  b_wr_data = 16'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("rnd_rst");
        if ($urandom_range(0, 1) == 0) tick("rnd_rst_held");
        #2 rst_n = 1'b1;
      end
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_select_bank.md
# reg_select_bank

Parametrised operand-select register bank for the 8-bit CPU datapath, replacing the fixed four-way combinational accumulator input select. Holds NREGS-1 writable general registers plus a live ALU-result slot at index 0. A registered read port drives the accumulator input with a valid strobe. Same-cycle write-to-read forwarding is built in.

## Interface
- WIDTH, 8, data width of registers, `alu_out` and `a_out`.
- NREGS, 4, number of selectable sources: index 0 is `alu_out`, indices 1..NREGS-1 are registers. Must be a power of two, >= 2.
- SEL_W, $clog2(NREGS), select width. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- alu_out  in  WIDTH  live ALU result, source index 0.
- wr_en  in  1  write strobe.
- wr_sel  in  SEL_W  destination register index.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_sel  in  SEL_W  source index.
- a_out  out  WIDTH  registered selected operand.
- a_valid  out  1  high for one cycle after each accepted read.
- wr_err  out  1  one-cycle pulse when a write targets index 0.

## Operation
- Storage: regs[1..NREGS-1], each WIDTH bits. Index 0 has no storage and always reads `alu_out`.
- **Write:** on a clk edge with wr_en=1 and wr_sel != 0, regs[wr_sel] <= wr_data.
- **Write to index 0:** with wr_en=1 and wr_sel == 0:
  - no register changes;
  - wr_err=1 on the next cycle.
  - wr_err is otherwise 0.
- **Read:** on a clk edge with rd_en=1:
  - a_out <= source(rd_sel);
  - a_valid <= 1.
- **Source selection:**
  - rd_sel == 0: source is `alu_out` as sampled at that edge.
  - rd_sel != 0, wr_en=1 and wr_sel == rd_sel in the same cycle: source is wr_data (forwarding; the new value is returned, not the old one).
  - otherwise: source is regs[rd_sel].
- **No read:** rd_en=0 → a_out holds its last value; a_valid <= 0.
- Simultaneous read and write to different indices are independent. Both complete in the same cycle.
- Out-of-range indices cannot occur because NREGS is a power of two.
- No arithmetic. Widths are exact with no truncation or extension.

## Timing
- **Reset (rst_n=0):** asynchronous; takes effect immediately, no clock needed.
  - all regs = 0;
  - a_out = 0;
  - a_valid = 0;
  - wr_err = 0.
  - Release is synchronous to the next clk edge.
- **Reset mid-operation:** a write or read in flight on the asserting edge is discarded. The first operation is accepted on the first edge with rst_n=1.
- **Read latency:** 1 cycle. With rd_en sampled high at edge N, a_out and a_valid are valid after edge N and stable until edge N+1.
- **Write latency:** 1 cycle. A read issued at edge N+1 returns the value written at edge N. A read issued at edge N with the same index also returns it, via forwarding.
- **Back-to-back:** rd_en may be high every cycle, giving one result per cycle with a_valid held high continuously.
- **wr_err:** asserted after the edge that sampled the illegal write; cleared after the next edge unless the illegal write repeats.
- a_out, a_valid and wr_err are all registered outputs. No combinational path runs from any input to any output.

## Test plan
- **Reset:** drive rst_n=0 mid-cycle with a_out=8'h55 → a_out=0, a_valid=0 and wr_err=0 immediately, before any clock edge. Release, then read indices 1..3 → 0 each.
- **Basic select:** alu_out=1; write 2, 3, 4 to regs 1..3; then read rd_sel=0,1,2,3 on consecutive cycles → a_out=1,2,3,4 one cycle after each request, with a_valid continuously high.
- **Forwarding:** regs[2]=3; in one cycle set wr_en=1, wr_sel=2, wr_data=8'hA5, rd_en=1, rd_sel=2 → a_out=8'hA5 next cycle. A following read of 2 also returns 8'hA5.
- **Illegal write:** wr_en=1, wr_sel=0, wr_data=8'hFF with alu_out=8'h10 → wr_err pulses for one cycle. A read of index 0 returns 8'h10, and regs 1..3 are unchanged.
- **Hold:** read index 3 (=4), then drop rd_en for 3 cycles while writing 8'h77 to reg 3 → a_out stays 4 and a_valid=0. The next read returns 8'h77.
- **Parameter sweep:** WIDTH=16, NREGS=8. Write i*16'h1111 to reg i for i=1..7, then read all 8 indices with alu_out=16'hBEEF → index 0 returns 16'hBEEF and index i returns i*16'h1111.
